iqueue: RTL and testbench

Instruction queue between the decoder and the issue/writeback MUX. Buffers decoded instructions (type, rd, pc, imm) in a circular FIFO and presents them one at a time to the MUX as registered single-cycle pulses. Obeys the MUX's `issue_rdy` back-pressure, including its one-cycle drop after a MEM issue. Supports a whole-queue flush on branch mispredict.

---
 rtl/iqueue.sv | 111 +++++++++++
 tb/tb_iqueue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/iqueue.sv
// Circular instruction queue between decoder and issue MUX; issues registered one-cycle pulses.
// Optional same-edge issue of an input into an empty queue when IQUEUE_BYPASS_EN is defined.
module iqueue #(
    parameter int         DEPTH_LOG2 = 3,
    parameter logic [2:0] MEM_TYPE   = 3'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [2:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    output logic        full,
    input  logic        issue_rdy,
    output logic        ins_rdy,
    output logic [2:0]  ins_type,
    output logic [4:0]  rd,
    output logic [31:0] pc,
    output logic [31:0] imm
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef struct packed {
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
    } entry_t;

    entry_t                r_mem [DEPTH];
    entry_t                r_out;
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_ins_rdy;

    entry_t                w_in;
    logic                  w_issue_ok;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_bypass;
    logic [DEPTH_LOG2:0]   w_count_next;

    assign full     = r_full;
    assign ins_rdy  = r_ins_rdy;
    assign ins_type = r_out.typ;
    assign rd       = r_out.rd;
    assign pc       = r_out.pc;
    assign imm      = r_out.imm;

    always_comb begin
        w_in       = '{typ: in_type, rd: in_rd, pc: in_pc, imm: in_imm};
        // The MUX drops issue_rdy the cycle after a MEM pulse; never issue into that cycle.
        w_issue_ok = issue_rdy && !(r_ins_rdy && (r_out.typ == MEM_TYPE));
`ifdef IQUEUE_BYPASS_EN
        w_bypass   = (r_count == '0) && in_valid && w_issue_ok;
`else
        w_bypass   = 1'b0;
`endif
        w_issue    = (r_count != '0) && w_issue_ok;
        w_push     = in_valid && !r_full && !w_bypass;

        w_count_next = r_count;
        if (w_push && !w_issue)
            w_count_next = r_count + 1'b1;
        else if (!w_push && w_issue)
            w_count_next = r_count - 1'b1;
        if (clear)
            w_count_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_ins_rdy <= 1'b0;
            r_out     <= '0;
        end else if (rdy) begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            if (clear) begin
                r_head    <= '0;
                r_tail    <= '0;
                r_ins_rdy <= 1'b0;
            end else begin
                if (w_push)
                    r_tail <= r_tail + 1'b1;
                if (w_issue)
                    r_head <= r_head + 1'b1;
                r_ins_rdy <= w_issue || w_bypass;
                if (w_issue)
                    r_out <= r_mem[r_head];
                else if (w_bypass)
                    r_out <= w_in;
            end
        end
    end

    // Entry storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rdy && w_push && !clear)
            r_mem[r_tail] <= w_in;
    end
endmodule

// File: tb/tb_iqueue.sv
// Directed self-checking bench for iqueue: ordering, full/wrap, MEM stall, flush, rdy freeze.
// Build with IQUEUE_BYPASS_EN defined to exercise the same-edge bypass path instead.
module tb_iqueue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_type = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_imm = 32'd0;
    logic        full;
    logic        issue_rdy = 1'b0;
    logic        ins_rdy;
    logic [2:0]  ins_type;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [2:0] T_ALU = 3'd0;
    localparam logic [2:0] T_MEM = 3'd1;

    iqueue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_type(in_type), .in_rd(in_rd),
        .in_pc(in_pc), .in_imm(in_imm), .full(full),
        .issue_rdy(issue_rdy), .ins_rdy(ins_rdy), .ins_type(ins_type),
        .rd(rd), .pc(pc), .imm(imm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] p);
        in_valid = v;
        in_type  = t;
        in_pc    = p;
        in_rd    = p[6:2];
        in_imm   = ~p;
    endtask

    initial begin
        #1;
        chk("rst_ins_rdy", ins_rdy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_count", dut.r_count, 4'd0);
        #11 rst = 1'b1;

`ifndef IQUEUE_BYPASS_EN
        // Three ALU instructions, streaming
        issue_rdy = 1'b1;
        drive(1'b1, T_ALU, 32'h0); tick();
        chk("t1_no_bypass", ins_rdy, 1'b0);
        drive(1'b1, T_ALU, 32'h4); tick();
        chk("t1_rdy0", ins_rdy, 1'b1);
        chk("t1_pc0", pc, 32'h0);
        chk("t1_imm0", imm, 32'hFFFF_FFFF);
        drive(1'b1, T_ALU, 32'h8); tick();
        chk("t1_rdy1", ins_rdy, 1'b1);
        chk("t1_pc1", pc, 32'h4);
        drive(1'b0, T_ALU, 32'h0); tick();
        chk("t1_rdy2", ins_rdy, 1'b1);
        chk("t1_pc2", pc, 32'h8);
        chk("t1_rd2", rd, 5'd2);
        tick();
        chk("t1_idle", ins_rdy, 1'b0);
        chk("t1_count", dut.r_count, 4'd0);

        // Fill to full with no issue, then drain across the pointer wrap
        issue_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, T_ALU, 32'h100 + 32'(4 * i)); tick();
        end
        chk("t2_full", full, 1'b1);
        chk("t2_count8", dut.r_count, 4'd8);
        drive(1'b1, T_ALU, 32'h120); tick();
        chk("t2_held", dut.r_count, 4'd8);
        issue_rdy = 1'b1; tick();
        chk("t2_first_pc", pc, 32'h100);
        chk("t2_full_drop", full, 1'b0);
        chk("t2_cnt7a", dut.r_count, 4'd7);
        tick();
        drive(1'b0, T_ALU, 32'h0);
        chk("t2_pc104", pc, 32'h104);
        chk("t2_cnt7b", dut.r_count, 4'd7);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("t2_drain_rdy", ins_rdy, 1'b1);
            chk("t2_drain_pc", pc, 32'h100 + 32'(4 * i));
        end
        tick();
        chk("t2_empty_rdy", ins_rdy, 1'b0);
        chk("t2_empty_cnt", dut.r_count, 4'd0);

        // MEM then ALU: MUX holds issue_rdy one cycle, then drops it for three
        issue_rdy = 1'b0;
        drive(1'b1, T_MEM, 32'h10); tick();
        drive(1'b1, T_ALU, 32'h14); tick();
        drive(1'b0, T_ALU, 32'h0);
        issue_rdy = 1'b1; tick();
        chk("t3_mem_rdy", ins_rdy, 1'b1);
        chk("t3_mem_pc", pc, 32'h10);
        chk("t3_mem_type", ins_type, T_MEM);
        tick();
        chk("t3_gap", ins_rdy, 1'b0);
        issue_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall", ins_rdy, 1'b0);
        end
        issue_rdy = 1'b1; tick();
        chk("t3_alu_rdy", ins_rdy, 1'b1);
        chk("t3_alu_pc", pc, 32'h14);
        tick();
        chk("t3_idle", ins_rdy, 1'b0);

        // Flush with 5 queued, concurrent push and issue_rdy
        issue_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, T_ALU, 32'h200 + 32'(4 * i)); tick();
        end
        chk("t4_cnt5", dut.r_count, 4'd5);
        drive(1'b1, T_ALU, 32'h2FC);
        issue_rdy = 1'b1;
        clear = 1'b1; tick();
        clear = 1'b0;
        drive(1'b0, T_ALU, 32'h0);
        chk("t4_cnt0", dut.r_count, 4'd0);
        chk("t4_rdy0", ins_rdy, 1'b0);
        chk("t4_full0", full, 1'b0);
        tick();
        chk("t4_push_lost", ins_rdy, 1'b0);

        // rdy freeze while a pulse is presented
        issue_rdy = 1'b0;
        drive(1'b1, T_ALU, 32'h300); tick();
        drive(1'b1, T_ALU, 32'h304); tick();
        drive(1'b0, T_ALU, 32'h0);
        issue_rdy = 1'b1; tick();
        chk("t5_pulse", ins_rdy, 1'b1);
        chk("t5_pc", pc, 32'h300);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_rdy", ins_rdy, 1'b1);
            chk("t5_hold_pc", pc, 32'h300);
        end
        rdy = 1'b1; tick();
        chk("t5_next_pc", pc, 32'h304);
        chk("t5_next_rdy", ins_rdy, 1'b1);
        issue_rdy = 1'b0; tick();
        chk("t5_idle", ins_rdy, 1'b0);
        chk("t5_cnt", dut.r_count, 4'd0);
`else
        // Same-edge bypass into an empty queue
        issue_rdy = 1'b1;
        drive(1'b1, T_ALU, 32'h20); tick();
        chk("bp_rdy", ins_rdy, 1'b1);
        chk("bp_pc", pc, 32'h20);
        chk("bp_cnt", dut.r_count, 4'd0);
        drive(1'b0, T_ALU, 32'h0); tick();
        chk("bp_idle", ins_rdy, 1'b0);
        chk("bp_cnt2", dut.r_count, 4'd0);
        drive(1'b1, T_ALU, 32'h24);
        clear = 1'b1; tick();
        clear = 1'b0;
        drive(1'b0, T_ALU, 32'h0);
        chk("bp_clear_rdy", ins_rdy, 1'b0);
        chk("bp_clear_pc", pc, 32'h20);
        chk("bp_clear_cnt", dut.r_count, 4'd0);
        issue_rdy = 1'b0;
        drive(1'b1, T_ALU, 32'h28); tick();
        drive(1'b0, T_ALU, 32'h0);
        chk("bp_store_cnt", dut.r_count, 4'd1);
        chk("bp_store_rdy", ins_rdy, 1'b0);
        issue_rdy = 1'b1; tick();
        chk("bp_store_pc", pc, 32'h28);
        chk("bp_store_iss", ins_rdy, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
